// File: rtl/ysyx_24080006_mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package ysyx_24080006_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULL = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_e mdu_op;
    } mdu_set_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] MDU_OVF_Q  = 32'h8000_0000;

    function automatic logic [32:0] ext33(input logic sgn, input logic [31:0] v);
        return {sgn & v[31], v};
    endfunction

    // Magnitude of a 33-bit two's complement value; -2^31 maps to 32'h8000_0000.
    function automatic logic [31:0] abs33(input logic [32:0] v);
        logic [32:0] n;
        n = 33'd0 - v;
        return v[32] ? n[31:0] : v[31:0];
    endfunction

    function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
        return neg ? (64'd0 - v) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_if.sv
// Issue/writeback handshake bundle between the execute stage and the MDU.
interface ysyx_24080006_mdu_if;
    import ysyx_24080006_mdu_pkg::*;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    mdu_set_t    mdu_set;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output flush, in_valid, mdu_set, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, mdu_set, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_24080006_mdu_div.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and emit the quotient bit.
module ysyx_24080006_mdu_div (
    input  logic [32:0] rem_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);
    logic [32:0] sub_s;

    // A set rem_in[32] already exceeds any 32-bit divisor; the wrapped low difference is exact.
    always_comb begin
        sub_s = {1'b0, rem_in[31:0]} - {1'b0, divisor};
        q_bit = rem_in[32] | ~sub_s[32];
        if (q_bit) begin
            rem_out = sub_s[31:0];
        end else begin
            rem_out = rem_in[31:0];
        end
    end
endmodule

// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit. Define YSYX_24080006_MDU_FAST_MUL_EN
// to replace the shift-add multiplier with a single-cycle 33x33 multiplier.
module ysyx_24080006_mdu
    import ysyx_24080006_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input logic                clock,
    input logic                reset,
    ysyx_24080006_mdu_if.slave bus
);
    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

    mdu_state_e  state_r;
    logic [4:0]  cnt_r;
    mdu_op_e     op_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic [31:0] opnd_r;
    logic [63:0] prod_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic [31:0] result_r;

    logic        accept_s;
    logic        in_div_s;
    logic        div_zero_s;
    logic        ovf_s;
    logic        special_s;
    logic [32:0] a_ext_s;
    logic [32:0] b_ext_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] special_res_s;
    logic [32:0] div_rem_in_s;
    logic [31:0] div_rem_out_s;
    logic        div_q_s;
    logic [63:0] div_next_s;
    logic [63:0] step_s;
    logic [63:0] mul_signed_s;
    logic [31:0] fin_res_s;
`ifdef YSYX_24080006_MDU_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    logic [31:0] fast_res_s;
`else
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
`endif

    // Operand extension, accept qualification and the accept-time special cases.
    always_comb begin
        a_ext_s    = ext33(bus.mdu_set.signed_a, bus.rs1_data);
        b_ext_s    = ext33(bus.mdu_set.signed_b, bus.rs2_data);
        mag_a_s    = abs33(a_ext_s);
        mag_b_s    = abs33(b_ext_s);
        in_div_s   = (bus.mdu_set.mdu_op == MDU_DIV) || (bus.mdu_set.mdu_op == MDU_REM);
        accept_s   = bus.in_valid & in_ready_r & bus.mdu_set.mdu_enable & ~bus.flush;
        div_zero_s = in_div_s & (bus.rs2_data == 32'd0);
        ovf_s      = in_div_s & bus.mdu_set.signed_a & bus.mdu_set.signed_b &
                     (bus.rs1_data == 32'h8000_0000) & (bus.rs2_data == 32'hFFFF_FFFF);
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            special_res_s = (bus.mdu_set.mdu_op == MDU_DIV) ? MDU_DIV0_Q : bus.rs1_data;
        end else if (ovf_s) begin
            special_res_s = (bus.mdu_set.mdu_op == MDU_DIV) ? MDU_OVF_Q : 32'd0;
        end else begin
            special_res_s = 32'd0;
        end
    end

    // Divide shares prod_r: high half is the partial remainder, low half shifts
    // dividend bits out and quotient bits in.
    assign div_rem_in_s = {prod_r[63:32], prod_r[31]};
    assign div_next_s   = {div_rem_out_s, prod_r[30:0], div_q_s};

    ysyx_24080006_mdu_div u_div (
        .rem_in  (div_rem_in_s),
        .divisor (opnd_r),
        .rem_out (div_rem_out_s),
        .q_bit   (div_q_s)
    );

`ifdef YSYX_24080006_MDU_FAST_MUL_EN
    // Single-cycle signed multiply on the 33-bit extended operands.
    always_comb begin
        fast_prod_s = 64'($signed(a_ext_s)) * 64'($signed(b_ext_s));
        if (bus.mdu_set.mdu_op == MDU_MULH) begin
            fast_res_s = fast_prod_s[63:32];
        end else begin
            fast_res_s = fast_prod_s[31:0];
        end
    end

    // Only division iterates in this build.
    always_comb begin
        step_s = div_next_s;
    end
`else
    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        mul_sum_s = {1'b0, prod_r[63:32]} + {1'b0, opnd_r};
        if (prod_r[0]) begin
            mul_next_s = {mul_sum_s, prod_r[31:1]};
        end else begin
            mul_next_s = {1'b0, prod_r[63:1]};
        end
        if ((op_r == MDU_DIV) || (op_r == MDU_REM)) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end
`endif

    // Sign fix-up of the final iteration's magnitude result.
    always_comb begin
        mul_signed_s = cond_neg64(sign_a_r ^ sign_b_r, step_s);
        case (op_r)
            MDU_MULL: fin_res_s = mul_signed_s[31:0];
            MDU_MULH: fin_res_s = mul_signed_s[63:32];
            MDU_DIV:  fin_res_s = cond_neg32(sign_a_r ^ sign_b_r, step_s[31:0]);
            MDU_REM:  fin_res_s = cond_neg32(sign_a_r, step_s[63:32]);
            default:  fin_res_s = 32'd0;
        endcase
    end

    // Control FSM with the iteration datapath and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            op_r        <= MDU_MULL;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            opnd_r      <= 32'd0;
            prod_r      <= 64'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            result_r    <= 32'd0;
        end else if (bus.flush) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r       <= bus.mdu_set.mdu_op;
                        sign_a_r   <= a_ext_s[32];
                        sign_b_r   <= b_ext_s[32];
                        in_ready_r <= 1'b0;
                        if (special_s) begin
                            state_r     <= DONE;
                            result_r    <= special_res_s;
                            out_valid_r <= 1'b1;
                        end
`ifdef YSYX_24080006_MDU_FAST_MUL_EN
                        else if (!in_div_s) begin
                            state_r     <= DONE;
                            result_r    <= fast_res_s;
                            out_valid_r <= 1'b1;
                        end
`endif
                        else begin
                            state_r <= CALC;
                            cnt_r   <= in_div_s ? DIV_LAST : MUL_LAST;
                            opnd_r  <= in_div_s ? mag_b_s : mag_a_s;
                            prod_r  <= {32'd0, (in_div_s ? mag_a_s : mag_b_s)};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    prod_r <= step_s;
                    if (cnt_r == 5'd0) begin
                        state_r     <= DONE;
                        result_r    <= fin_res_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Directed self-checking bench for ysyx_24080006_mdu (either multiplier build).
module tb_ysyx_24080006_mdu;
    import ysyx_24080006_mdu_pkg::*;

`ifdef YSYX_24080006_MDU_FAST_MUL_EN
    localparam logic [31:0] MUL_LAT = 32'd1;
`else
    localparam logic [31:0] MUL_LAT = 32'd33;
`endif
    localparam logic [31:0] DIV_LAT = 32'd33;
    localparam logic [31:0] SPC_LAT = 32'd1;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    ysyx_24080006_mdu_if mdu_bus ();

    ysyx_24080006_mdu #(
        .MUL_CYCLES (32),
        .DIV_CYCLES (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mdu_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic en, input mdu_op_e op, input logic sa, input logic sb,
                            input logic [31:0] a, input logic [31:0] b);
        mdu_bus.in_valid            = 1'b1;
        mdu_bus.mdu_set.mdu_enable  = en;
        mdu_bus.mdu_set.signed_a    = sa;
        mdu_bus.mdu_set.signed_b    = sb;
        mdu_bus.mdu_set.mdu_op      = op;
        mdu_bus.rs1_data            = a;
        mdu_bus.rs2_data            = b;
    endtask

    // Called at the negedge before the accept edge with the op already driven.
    task automatic finish_op(input string tag, input logic [31:0] exp, input logic [31:0] exp_lat);
        int lat;
        @(posedge clock);
        @(negedge clock);
        mdu_bus.in_valid = 1'b0;
        lat = 1;
        while (mdu_bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check_value({tag, "_lat"}, 32'(lat), exp_lat);
        check_value({tag, "_res"}, mdu_bus.result, exp);
        mdu_bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        mdu_bus.out_ready = 1'b0;
        check_value({tag, "_idle"}, {31'd0, mdu_bus.in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input mdu_op_e op, input logic sa, input logic sb,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [31:0] exp_lat);
        check_value({tag, "_rdy"}, {31'd0, mdu_bus.in_ready}, 32'd1);
        drive_op(1'b1, op, sa, sb, a, b);
        finish_op(tag, exp, exp_lat);
    endtask

    initial begin
        logic seen;
        int   lat;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        mdu_bus.flush     = 1'b0;
        mdu_bus.in_valid  = 1'b0;
        mdu_bus.out_ready = 1'b0;
        mdu_bus.mdu_set   = '0;
        mdu_bus.rs1_data  = 32'd0;
        mdu_bus.rs2_data  = 32'd0;
        repeat (2) @(negedge clock);
        check_value("rst_in_ready", {31'd0, mdu_bus.in_ready}, 32'd1);
        check_value("rst_out_valid", {31'd0, mdu_bus.out_valid}, 32'd0);
        check_value("rst_result", mdu_bus.result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op("mull_ss",    MDU_MULL, 1'b1, 1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh_ss",    MDU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulh_uu",    MDU_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_su",    MDU_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mull_uu",    MDU_MULL, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);
        run_op("mulh_uu2",   MDU_MULH, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, MUL_LAT);
        run_op("div_ss",     MDU_DIV,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_ss",     MDU_REM,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_ss_nb",  MDU_DIV,  1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_ss_nb",  MDU_REM,  1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        run_op("div_uu",     MDU_DIV,  1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        DIV_LAT);
        run_op("rem_uu",     MDU_REM,  1'b0, 1'b0, 32'd100,       32'd7,         32'd2,         DIV_LAT);
        run_op("div_zero",   MDU_DIV,  1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        run_op("rem_zero",   MDU_REM,  1'b0, 1'b0, 32'd5,         32'd0,         32'd5,         SPC_LAT);
        run_op("div_ovf",    MDU_DIV,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        run_op("rem_ovf",    MDU_REM,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPC_LAT);

        // Flush at cycle 10 of a divide, then a fresh multiply accepted at cycle 11.
        drive_op(1'b1, MDU_DIV, 1'b0, 1'b0, 32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        mdu_bus.in_valid = 1'b0;
        seen = mdu_bus.out_valid;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clock);
            seen = seen | mdu_bus.out_valid;
        end
        mdu_bus.flush = 1'b1;
        drive_op(1'b1, MDU_MULL, 1'b0, 1'b0, 32'd3, 32'd4);
        @(negedge clock);
        mdu_bus.flush = 1'b0;
        seen = seen | mdu_bus.out_valid;
        check_value("flush_no_valid", {31'd0, seen}, 32'd0);
        check_value("flush_idle", {31'd0, mdu_bus.in_ready}, 32'd1);
        finish_op("flush_mull", 32'd12, MUL_LAT);

        // Flush beats an in_valid presented in IDLE.
        drive_op(1'b1, MDU_DIV, 1'b0, 1'b0, 32'd9, 32'd3);
        mdu_bus.flush = 1'b1;
        @(negedge clock);
        mdu_bus.flush    = 1'b0;
        mdu_bus.in_valid = 1'b0;
        check_value("flush_beats_accept", {31'd0, mdu_bus.in_ready}, 32'd1);

        // A disabled bundle is ignored.
        drive_op(1'b0, MDU_DIV, 1'b0, 1'b0, 32'd9, 32'd0);
        @(negedge clock);
        check_value("disabled_rdy", {31'd0, mdu_bus.in_ready}, 32'd1);
        @(negedge clock);
        mdu_bus.in_valid = 1'b0;
        check_value("disabled_valid", {31'd0, mdu_bus.out_valid}, 32'd0);

        // Backpressure: result and in_ready hold while out_ready stays low.
        drive_op(1'b1, MDU_DIV, 1'b0, 1'b0, 32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        mdu_bus.in_valid = 1'b0;
        lat = 1;
        while (mdu_bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check_value("bp_lat", 32'(lat), DIV_LAT);
        for (int k = 0; k < 5; k++) begin
            check_value("bp_result", mdu_bus.result, 32'd14);
            check_value("bp_in_ready", {31'd0, mdu_bus.in_ready}, 32'd0);
            @(negedge clock);
        end
        check_value("bp_valid_held", {31'd0, mdu_bus.out_valid}, 32'd1);
        mdu_bus.out_ready = 1'b1;
        check_value("bp_rdy_before_hs", {31'd0, mdu_bus.in_ready}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        mdu_bus.out_ready = 1'b0;
        check_value("bp_rdy_after_hs", {31'd0, mdu_bus.in_ready}, 32'd1);
        check_value("bp_valid_after_hs", {31'd0, mdu_bus.out_valid}, 32'd0);

        // Reset in the middle of an operation discards it.
        drive_op(1'b1, MDU_MULH, 1'b1, 1'b1, 32'd1000, 32'd1000);
        @(posedge clock);
        @(negedge clock);
        mdu_bus.in_valid = 1'b0;
        check_value("mid_busy", {31'd0, mdu_bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_value("mid_rst_valid", {31'd0, mdu_bus.out_valid}, 32'd0);
        check_value("mid_rst_rdy", {31'd0, mdu_bus.in_ready}, 32'd1);
        check_value("mid_rst_result", mdu_bus.result, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_value("mid_rst_no_result", {31'd0, mdu_bus.out_valid}, 32'd0);

        run_op("post_rst_div", MDU_DIV, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, DIV_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_24080006_mdu.md
# ysyx_24080006_mdu

Iterative multiply/divide unit for the RV32M extension. It sits in the execute stage beside the ALU and consumes the `mdu_set_t` control bundle produced by the decoder together with the rs1/rs2 operands. It returns a 32-bit result to writeback through a valid/ready handshake. The issue logic stalls the pipeline while the unit reports not-ready.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: iteration count for shift-add multiply. Fixed at 32; exposed for the bench only.
- `DIV_CYCLES`, default 32: iteration count for restoring divide. Fixed at 32.

Ports:
- `clock`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  kill the in-flight operation (branch mispredict or trap).
- `in_valid`  in  1  operands and `mdu_set` are valid.
- `in_ready`  out  1  high only in IDLE.
- `mdu_set`  in  `mdu_set_t`  fields `mdu_enable`, `signed_a`, `signed_b`, `mdu_op` (MULL/MULH/DIV/REM).
- `rs1_data`  in  32  dividend or multiplicand.
- `rs2_data`  in  32  divisor or multiplier.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts the result.
- `result`  out  32  the operation result.

## Operation
- **Accept:** an operation is accepted when `in_valid & in_ready & mdu_set.mdu_enable & ~flush`. Operands, op and signedness are latched.
- **Operand extension:** each operand is extended to 33 bits, sign-extended if its `signed_*` bit is set, zero-extended otherwise. Each magnitude is then taken, and the signs are recorded.
- **Multiply:** shift-add over 32 iterations produces a 64-bit magnitude product. The product is negated if `sign_a ^ sign_b`.
  - MULL returns `[31:0]`; MULH returns `[63:32]`.
  - MULH covers MULH, MULHSU and MULHU through the signed bits.
- **Divide:** restoring division, one quotient bit per cycle.
  - Quotient is negated if `sign_a ^ sign_b`.
  - Remainder takes the dividend's sign.
- **Divide by zero:** detected at accept; no iteration. DIV returns `32'hFFFF_FFFF`; REM returns `rs1_data`.
- **Signed overflow:** `rs1 == 32'h8000_0000`, `rs2 == 32'hFFFF_FFFF`, both signed. Detected at accept; no iteration. DIV returns `32'h8000_0000`; REM returns 0.
- **States:**
  - IDLE: goes to CALC on accept, or straight to DONE on a special case.
  - CALC: a 5-bit counter counts down from 31; goes to DONE when the counter reaches 0.
  - DONE: goes to IDLE on `out_ready`.
- **Flush:** any state goes to IDLE on the next edge. `out_valid` drops and no result is delivered. Flush beats a simultaneous `in_valid` (no accept) and a simultaneous `out_ready`.
- **Reset values:** state IDLE, `out_valid` 0, `result` 0, counter 0. `in_ready` is 1 after reset.
- **Reset mid-operation:** the operation is discarded.
- **Disabled bundle:** `in_valid` with `mdu_enable` low is ignored.

## Timing
- Call the accept edge cycle 0.
- Normal mul/div: `out_valid` is asserted from cycle 33.
- Special cases (divide by zero, overflow): `out_valid` is asserted from cycle 1.
- `result` is registered and stable for as long as `out_valid` is high.
- The handshake completes on the edge where `out_valid & out_ready`. `in_ready` rises the following cycle; there is no back-to-back accept in the same cycle as completion.
- `in_ready` is a pure function of state, with no combinational path from `in_valid`.
- `out_valid` has no combinational dependence on `out_ready`.

## Configuration
- Macro `YSYX_24080006_MDU_FAST_MUL_EN`.
- **Defined:**
  - MULL and MULH use a single-cycle 33x33 signed combinational multiplier.
  - The path is IDLE to DONE, with `out_valid` at cycle 1. The multiply iteration datapath is omitted.
  - Division is unchanged.
- **Undefined:** the iterative shift-add multiply described above, 33-cycle latency.
- Results are bit-identical in both builds.

## Structure
- The shared package already holds `mdu_op_e` and `mdu_set_t`.
- Add `mdu_state_e` (IDLE, CALC, DONE) to the package.
- Add `MDU_DIV0_Q = 32'hFFFF_FFFF` to the package.
- Sub-module `ysyx_24080006_mdu_div`: restoring divide step. Inputs are the partial remainder and divisor magnitude; outputs are the next remainder and the quotient bit.
- The multiplier step, sign handling and FSM stay in the top module.

## Test plan
- MULL, signed, 7 × 0xFFFF_FFFD: `result` 0xFFFF_FFEB. `out_valid` at cycle 33, or at cycle 1 with FAST_MUL.
- MULH, signed×signed, 0x8000_0000 × 0x8000_0000: 0x4000_0000.
- MULH, unsigned×unsigned, 0xFFFF_FFFF × 0xFFFF_FFFF: 0xFFFF_FFFE.
- MULH, signed×unsigned, 0xFFFF_FFFF × 0xFFFF_FFFF: 0xFFFF_FFFF.
- DIV signed −7/2: 0xFFFF_FFFD. REM signed −7/2: 0xFFFF_FFFF. Unsigned DIV 100/7: 14. Unsigned REM 100/7: 2.
- DIV unsigned 5/0: 0xFFFF_FFFF at cycle 1. REM 5/0: 5.
- DIV signed 0x8000_0000/0xFFFF_FFFF: 0x8000_0000. REM of the same operands: 0. Both at cycle 1.
- `flush` at cycle 10 of a DIV:
  - IDLE at cycle 11, with `out_valid` never asserted.
  - A new MULL 3×4 accepted at cycle 11 returns 12.
- Backpressure: `out_ready` held low 5 cycles after `out_valid` rises. `result` stays stable; `in_ready` stays low until one cycle after the handshake.
